// File: rtl/bcd_counter_mux7.sv
// Multi-digit BCD up/down counter with tick prescaler, wrap/saturate limits,
// clamped load, and a time-multiplexed active-low 7-segment digit scanner.
module bcd_counter_mux7 #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000000,
  parameter int SCAN_DIV = 100000,
  parameter int SAT      = 0,
  parameter int LZB      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  upDown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  at_limit,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg7
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RESET  = ~(DIGITS'(1));

  function automatic logic [CW-1:0] all_nines();
    logic [CW-1:0] r;
    r = {CW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] ALL_NINES = all_nines();

  // Out-of-range digits collapse to 9 so the counter never holds non-BCD values.
  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Returns {carry_out, sum}; carry_out set only when the input was all-9s.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  // Returns {borrow_out, difference}; borrow_out set only when the input was all-0s.
  function automatic logic [CW:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {b, r};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     pre_r;
  logic [SW-1:0]     scan_r;
  logic [IW-1:0]     idx_r;
  logic [CW-1:0]     count_r;
  logic              wrap_r;
  logic [DIGITS-1:0] an_r;

  logic              tick_s;
  logic              scan_end_s;
  logic [IW-1:0]     idx_nxt_s;
  logic [DIGITS-1:0] an_nxt_s;
  logic [CW:0]       inc_s;
  logic [CW:0]       dec_s;
  logic [CW:0]       step_s;
  logic [CW-1:0]     count_nxt_s;
  logic              wrap_nxt_s;
  logic [DIGITS-1:0] blank_s;
  logic              zero_above_s;
  logic [3:0]        digit_s;
  logic [6:0]        seg_s;

  assign tick_s     = (pre_r == PRE_LAST);
  assign scan_end_s = (scan_r == SCAN_LAST);

  // Next count: load wins over a tick; a limit crossing either wraps or holds.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    inc_s       = bcd_inc(count_r);
    dec_s       = bcd_dec(count_r);
    step_s      = upDown ? inc_s : dec_s;
    if (load) begin
      count_nxt_s = bcd_clamp(load_val);
    end else if (tick_s && enable) begin
      if (step_s[CW] && (SAT != 0)) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = step_s[CW-1:0];
        wrap_nxt_s  = step_s[CW];
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Tick prescaler and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      if (load || tick_s) begin
        pre_r <= {PW{1'b0}};
      end else begin
        pre_r <= pre_r + PW'(1'b1);
      end
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  // Digit index advance and its one-hot active-low anode pattern.
  always_comb begin
    idx_nxt_s = idx_r;
    an_nxt_s  = {DIGITS{1'b1}};
    if (scan_end_s) begin
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = {IW{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IW'(1'b1);
      end
    end else begin
      idx_nxt_s = idx_r;
    end
    for (int i = 0; i < DIGITS; i++) begin
      an_nxt_s[i] = (idx_nxt_s != IW'(i));
    end
  end

  // Scan prescaler, digit index and anode register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_r <= {SW{1'b0}};
      idx_r  <= {IW{1'b0}};
      an_r   <= AN_RESET;
    end else begin
      if (scan_end_s) begin
        scan_r <= {SW{1'b0}};
      end else begin
        scan_r <= scan_r + SW'(1'b1);
      end
      idx_r <= idx_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  // Segment drive for the selected digit, with optional leading-zero blanking.
  always_comb begin
    blank_s      = {DIGITS{1'b0}};
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above_s = zero_above_s & (count_r[4*i +: 4] == 4'd0);
      blank_s[i]   = zero_above_s;
    end
    digit_s = count_r[{idx_r, 2'b00} +: 4];
    if ((LZB != 0) && blank_s[idx_r]) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg_encode(digit_s);
    end
  end

  assign count    = count_r;
  assign wrap     = wrap_r;
  assign an       = an_r;
  assign seg7     = seg_s;
  assign at_limit = upDown ? (count_r == ALL_NINES) : (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_bcd_counter_mux7.sv
// Bench for bcd_counter_mux7: a wrapping/LZB instance and a saturating instance
// share stimulus and are checked every cycle against a decimal reference model.
module tb_bcd_counter_mux7;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       enable   = 1'b0;
  logic       up_down  = 1'b1;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] c0, c1;
  logic       w0, w1, l0, l1;
  logic [1:0] an0, an1;
  logic [6:0] s0, s1;

  int checks = 0;
  int errors = 0;

  // Reference model: counter values as plain integers 0..99.
  int         ph;
  int         n;
  int         v [2];
  bit         wr [2];
  logic [6:0] segtab [10];

  always #5 clk = ~clk;

  bcd_counter_mux7 #(.DIGITS(2), .DIV(4), .SCAN_DIV(2), .SAT(0), .LZB(1)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
    .load_val(load_val), .count(c0), .wrap(w0), .at_limit(l0), .an(an0), .seg7(s0)
  );

  bcd_counter_mux7 #(.DIGITS(2), .DIV(4), .SCAN_DIV(2), .SAT(1), .LZB(0)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
    .load_val(load_val), .count(c1), .wrap(w1), .at_limit(l1), .an(an1), .seg7(s1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_val(input logic [7:0] lv);
    int d0, d1;
    d0 = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    d1 = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    return d1 * 10 + d0;
  endfunction

  task automatic model_reset();
    ph = 0;
    n  = 0;
    for (int k = 0; k < 2; k++) begin
      v[k]  = 0;
      wr[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] c, input logic w, input logic l,
                           input logic [1:0] a, input logic [6:0] s);
    int         idx, dig;
    logic [1:0] ea;
    logic [6:0] es;
    logic [7:0] ec;
    idx = (n / 2) % 2;
    ea  = (idx == 0) ? 2'b10 : 2'b01;
    dig = (idx == 0) ? v[k] % 10 : v[k] / 10;
    es  = (k == 0 && idx == 1 && v[k] / 10 == 0) ? 7'b1111111 : segtab[dig];
    ec  = {4'(v[k] / 10), 4'(v[k] % 10)};
    chk($sformatf("u%0d.count", k), c, ec);
    chk($sformatf("u%0d.wrap", k), w, wr[k]);
    chk($sformatf("u%0d.at_limit", k), l, up_down ? (v[k] == 99) : (v[k] == 0));
    chk($sformatf("u%0d.an", k), a, ea);
    chk($sformatf("u%0d.seg7", k), s, es);
  endtask

  task automatic check_all();
    check_dut(0, c0, w0, l0, an0, s0);
    check_dut(1, c1, w1, l1, an1, s1);
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic cyc();
    bit tk;
    @(posedge clk);
    tk = (ph == 3);
    for (int k = 0; k < 2; k++) begin
      wr[k] = 1'b0;
      if (load) begin
        v[k] = clamp_val(load_val);
      end else if (tk && enable) begin
        if (up_down) begin
          if (v[k] < 99) v[k] = v[k] + 1;
          else if (k == 0) begin v[k] = 0; wr[k] = 1'b1; end
        end else begin
          if (v[k] > 0) v[k] = v[k] - 1;
          else if (k == 0) begin v[k] = 99; wr[k] = 1'b1; end
        end
      end
    end
    ph = load ? 0 : (ph + 1) % 4;
    n++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_an", an0, 2'b10);
    chk("rst_seg7", s0, 7'b1000000);
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    model_reset();
    #1 rst = 1'b0;
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;

    // Up count from reset: 00..10, one step every 4 cycles.
    enable  = 1'b1;
    up_down = 1'b1;
    repeat (40) cyc();
    chk("up_to_10", c0, 8'h10);

    // Load 99 and count up: wrapping instance rolls over, saturating one holds.
    load = 1'b1; load_val = 8'h99;
    cyc();
    load = 1'b0;
    repeat (4) cyc();
    chk("up_wrap_count", c0, 8'h00);
    chk("up_wrap_pulse", w0, 1'b1);
    chk("sat_hold", c1, 8'h99);
    cyc();
    chk("wrap_one_cycle", w0, 1'b0);
    repeat (7) cyc();
    chk("sat_hold3", c1, 8'h99);
    chk("sat_limit", l1, 1'b1);

    // Down from 00.
    up_down = 1'b0;
    load = 1'b1; load_val = 8'h00;
    cyc();
    load = 1'b0;
    chk("down_limit_pre", l0, 1'b1);
    repeat (4) cyc();
    chk("down_wrap_count", c0, 8'h99);
    chk("down_wrap_pulse", w0, 1'b1);
    chk("sat_low_hold", c1, 8'h00);

    // Load with clamp on a tick cycle; prescaler restarts.
    up_down = 1'b1;
    for (int g = 0; g < 4 && ph != 3; g++) cyc();
    load = 1'b1; load_val = 8'hA5;
    cyc();
    load = 1'b0;
    chk("load_clamp", c0, 8'h95);
    repeat (3) cyc();
    chk("load_restart_hold", c0, 8'h95);
    cyc();
    chk("load_restart_tick", c0, 8'h96);

    // Scan with leading-zero blanking, then an asynchronous reset mid-scan.
    enable = 1'b0;
    load = 1'b1; load_val = 8'h05;
    cyc();
    load = 1'b0;
    repeat (7) cyc();
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      up_down = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 8'h99;
        1:       load_val = 8'h00;
        default: load_val = 8'($urandom);
      endcase
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
